// File: rtl/swg_seq_pkg.sv
// Shared types and default widths for the sliding-window-generator loop sequencer.
// The configuration word carries the iteration counts, head increments and tail increments of one feature map.
package swg_seq_pkg;

  localparam int unsigned DEF_INCR_BITWIDTH = 9;
  localparam int unsigned DEF_CNT_BITWIDTH  = 8;
  localparam int unsigned NUM_LEVELS        = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Level numbering matches the counter index, innermost first.
  typedef enum logic [2:0] {
    LVL_SIMD = 3'd0,
    LVL_KW   = 3'd1,
    LVL_KH   = 3'd2,
    LVL_W    = 3'd3,
    LVL_H    = 3'd4,
    LVL_LAST = 3'd5
  } level_e;

  typedef struct packed {
    logic [DEF_CNT_BITWIDTH-1:0]         iter_h;
    logic [DEF_CNT_BITWIDTH-1:0]         iter_w;
    logic [DEF_CNT_BITWIDTH-1:0]         iter_kh;
    logic [DEF_CNT_BITWIDTH-1:0]         iter_kw;
    logic [DEF_CNT_BITWIDTH-1:0]         iter_simd;
    logic signed [DEF_INCR_BITWIDTH-1:0] head_simd;
    logic signed [DEF_INCR_BITWIDTH-1:0] head_kw;
    logic signed [DEF_INCR_BITWIDTH-1:0] head_kh;
    logic signed [DEF_INCR_BITWIDTH-1:0] head_w;
    logic signed [DEF_INCR_BITWIDTH-1:0] head_h;
    logic [DEF_INCR_BITWIDTH-1:0]        tail_w;
    logic [DEF_INCR_BITWIDTH-1:0]        tail_h;
    logic [DEF_INCR_BITWIDTH-1:0]        tail_last;
  } cfg_t;

  function automatic logic [DEF_CNT_BITWIDTH-1:0] cfg_iter(input cfg_t c, input int unsigned lvl);
    logic [DEF_CNT_BITWIDTH-1:0] it;
    case (lvl)
      0:       it = c.iter_simd;
      1:       it = c.iter_kw;
      2:       it = c.iter_kh;
      3:       it = c.iter_w;
      default: it = c.iter_h;
    endcase
    return it;
  endfunction

endpackage

// File: rtl/swg_seq_loop_counter.sv
// One loop level: down-counter reloaded to iter-1 (iter of 0 behaves as 1), never wraps below 0.
module swg_seq_loop_counter
  import swg_seq_pkg::*;
#(
  parameter int unsigned W = DEF_CNT_BITWIDTH
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] iter_i,
  input  logic         dec_i,
  output logic         is_zero_o
);

  logic [W-1:0] cnt_q, cnt_d, reload;

  always_comb begin
    reload = (iter_i == '0) ? '0 : iter_i - W'(1);
    cnt_d  = cnt_q;
    if (load_i) begin
      cnt_d = reload;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_zero_o = (cnt_q == '0);

endmodule

// File: rtl/swg_loop_sequencer.sv
// Five-level loop nest (H, W, KH, KW, SIMD) emitting per-fetch read-address and tail increments.
// A shadow register holds the next configuration; it is swapped in only at a feature-map boundary.
module swg_loop_sequencer
  import swg_seq_pkg::*;
#(
  parameter int unsigned INCR_BITWIDTH = DEF_INCR_BITWIDTH,
  parameter int unsigned CNT_BITWIDTH  = DEF_CNT_BITWIDTH
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst,
  // cfg_valid/cfg_ready: a configuration transfers on a rising edge where both are high;
  // cfg_ready depends only on the shadow register, never on cfg_valid.
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  cfg_t                            cfg_data,
  input  logic                            advance,
  output logic                            running,
  output logic signed [INCR_BITWIDTH-1:0] addr_incr,
  output logic [INCR_BITWIDTH-1:0]        tail_incr,
  output logic                            fm_last,
  output state_e                          dbg_state_o
);

  state_e                state_q, state_d;
  cfg_t                  shadow_q, shadow_d, active_q, active_d, load_src;
  logic                  shadow_full_q, shadow_full_d;
  logic [NUM_LEVELS-1:0] cnt_zero, cnt_load, cnt_dec;
  level_e                sel;
  logic                  adv_run, swap;

  // FSM: state register
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (shadow_full_q) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    running     = (state_q == RUN);
    cfg_ready   = !shadow_full_q;
    dbg_state_o = state_q;
  end

  // Innermost level with a nonzero counter is the one that steps on the next advance.
  always_comb begin
    sel = LVL_LAST;
    for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
      if (!cnt_zero[i]) sel = level_e'(3'(i));
    end
  end

  assign adv_run  = advance && (state_q == RUN);
  assign swap     = (state_q == LOAD) || (adv_run && (sel == LVL_LAST) && shadow_full_q);
  assign load_src = swap ? shadow_q : active_q;

  always_comb begin
    cnt_dec  = '0;
    cnt_load = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      cnt_dec[i]  = adv_run && (sel == level_e'(3'(i)));
      cnt_load[i] = (state_q == LOAD) || (adv_run && (3'(sel) > 3'(i)));
    end
  end

  for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_cnt
    swg_seq_loop_counter #(
      .W(CNT_BITWIDTH)
    ) u_cnt (
      .clk_i    (ap_clk),
      .rst_i    (ap_rst),
      .load_i   (cnt_load[g]),
      .iter_i   (cfg_iter(load_src, g)),
      .dec_i    (cnt_dec[g]),
      .is_zero_o(cnt_zero[g])
    );
  end

  // A handshake and a swap can never coincide: the swap needs a full shadow, the handshake an empty one.
  always_comb begin
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    active_d      = active_q;
    if (swap) begin
      active_d      = shadow_q;
      shadow_full_d = 1'b0;
    end
    if (cfg_valid && cfg_ready) begin
      shadow_d      = cfg_data;
      shadow_full_d = 1'b1;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      active_q      <= '0;
    end else begin
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      active_q      <= active_d;
    end
  end

  // Decoded purely from the counters, active config and state register.
  always_comb begin
    addr_incr = '0;
    tail_incr = '0;
    fm_last   = 1'b0;
    if (running) begin
      case (sel)
        LVL_SIMD: addr_incr = active_q.head_simd;
        LVL_KW:   addr_incr = active_q.head_kw;
        LVL_KH:   addr_incr = active_q.head_kh;
        LVL_W:    addr_incr = active_q.head_w;
        default:  addr_incr = active_q.head_h;
      endcase
      if (!cnt_zero[3]) begin
        tail_incr = active_q.tail_w;
      end else if (!cnt_zero[4]) begin
        tail_incr = active_q.tail_h;
      end else begin
        tail_incr = active_q.tail_last;
      end
      fm_last = (sel == LVL_LAST);
    end
  end

endmodule

// File: tb/tb_swg_loop_sequencer.sv
// Self-checking bench for swg_loop_sequencer: a loop-nest reference model feeds an expected queue
// that is drained one entry per fetch; scenario tasks add directed checks on top.
module tb_swg_loop_sequencer;
  import swg_seq_pkg::*;

  localparam int IW = DEF_INCR_BITWIDTH;
  localparam int EW = 2 * IW + 1;

  logic                 ap_clk = 1'b0;
  logic                 ap_rst;
  logic                 cfg_valid;
  logic                 cfg_ready;
  cfg_t                 cfg_data;
  logic                 advance;
  logic                 running;
  logic signed [IW-1:0] addr_incr;
  logic [IW-1:0]        tail_incr;
  logic                 fm_last;
  state_e               dbg_state;

  int checks = 0;
  int errors = 0;

  // Expected {addr_incr, tail_incr, fm_last} per fetch.
  logic [EW-1:0] exp_q[$];

  cfg_t m_active, m_pend;
  bit   m_pending;
  int   m_state;  // 0 idle, 1 loading, 2 running

  cfg_t cfg_a, cfg_a0, cfg_b, cfg_z;

  swg_loop_sequencer dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_data   (cfg_data),
    .advance    (advance),
    .running    (running),
    .addr_incr  (addr_incr),
    .tail_incr  (tail_incr),
    .fm_last    (fm_last),
    .dbg_state_o(dbg_state)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic cfg_t make_cfg(input int ih, input int iw, input int ikh, input int ikw, input int is,
                                    input int hs, input int hkw, input int hkh, input int hw, input int hh,
                                    input int tw, input int th, input int tl);
    cfg_t c;
    c.iter_h    = 8'(ih);
    c.iter_w    = 8'(iw);
    c.iter_kh   = 8'(ikh);
    c.iter_kw   = 8'(ikw);
    c.iter_simd = 8'(is);
    c.head_simd = 9'(hs);
    c.head_kw   = 9'(hkw);
    c.head_kh   = 9'(hkh);
    c.head_w    = 9'(hw);
    c.head_h    = 9'(hh);
    c.tail_w    = 9'(tw);
    c.tail_h    = 9'(th);
    c.tail_last = 9'(tl);
    return c;
  endfunction

  function automatic int eff(input logic [DEF_CNT_BITWIDTH-1:0] v);
    return (v == 0) ? 1 : int'(v);
  endfunction

  // Walk the loop nest: each fetch uses the head of the innermost level not at its final index.
  task automatic push_map(input cfg_t c);
    int nh, nw, nkh, nkw, ns;
    nh = eff(c.iter_h); nw = eff(c.iter_w); nkh = eff(c.iter_kh); nkw = eff(c.iter_kw); ns = eff(c.iter_simd);
    for (int h = 0; h < nh; h++)
      for (int w = 0; w < nw; w++)
        for (int kh = 0; kh < nkh; kh++)
          for (int kw = 0; kw < nkw; kw++)
            for (int s = 0; s < ns; s++) begin
              logic [IW-1:0] a, t;
              logic          l;
              l = 1'b0;
              if (s != ns - 1)        a = c.head_simd;
              else if (kw != nkw - 1) a = c.head_kw;
              else if (kh != nkh - 1) a = c.head_kh;
              else if (w != nw - 1)   a = c.head_w;
              else if (h != nh - 1)   a = c.head_h;
              else begin a = c.head_h; l = 1'b1; end
              t = (w != nw - 1) ? c.tail_w : ((h != nh - 1) ? c.tail_h : c.tail_last);
              exp_q.push_back({a, t, l});
            end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pending = 1'b0;
    m_state   = 0;
    m_active  = '0;
    m_pend    = '0;
  endtask

  // One clock cycle: check outputs against the model, drive inputs, advance the model at the edge.
  task automatic step(input bit adv, input bit offer, input cfg_t c, input string tag);
    logic [EW-1:0] exp_out, got;
    bit            exp_ready, hs;
    exp_ready = !m_pending;
    checks++;
    if (cfg_ready !== exp_ready) begin
      errors++;
      $display("FAIL %s cfg_ready: got %b, expected %b", tag, cfg_ready, exp_ready);
    end
    checks++;
    if (running !== (m_state == 2)) begin
      errors++;
      $display("FAIL %s running: got %b, expected %b", tag, running, (m_state == 2));
    end
    got = {addr_incr, tail_incr, fm_last};
    if (m_state == 2 && exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got %h, expected queue empty", tag, got);
    end else begin
      exp_out = (m_state == 2) ? exp_q[0] : '0;
      checks++;
      if (got !== exp_out) begin
        errors++;
        $display("FAIL %s outputs {addr,tail,last}: got %h, expected %h", tag, got, exp_out);
      end
    end
    advance   = adv;
    cfg_valid = offer;
    cfg_data  = c;
    @(posedge ap_clk);
    hs = offer && exp_ready;
    case (m_state)
      0: if (m_pending) m_state = 1;
      1: begin
        m_state   = 2;
        m_active  = m_pend;
        m_pending = 1'b0;
        push_map(m_active);
      end
      default: if (adv && exp_q.size() > 0) begin
        exp_out = exp_q.pop_front();
        if (exp_out[0]) begin
          if (m_pending) begin
            m_active  = m_pend;
            m_pending = 1'b0;
          end
          push_map(m_active);
        end
      end
    endcase
    if (hs) begin
      m_pending = 1'b1;
      m_pend    = c;
    end
    @(negedge ap_clk);
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    advance   = 1'b0;
    cfg_valid = 1'b0;
    ap_rst    = 1'b1;
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    model_reset();
  endtask

  task automatic start_cfg(input cfg_t c);
    step(1'b0, 1'b1, c, "handshake");
    step(1'b0, 1'b0, cfg_z, "idle_to_load");
    step(1'b0, 1'b0, cfg_z, "load_to_run");
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({running, addr_incr, tail_incr, fm_last} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got %b %h %h %b, expected all 0", running, addr_incr, tail_incr, fm_last);
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset cfg_ready: got %b, expected 1", cfg_ready);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset state: got %0d, expected %0d", dbg_state, IDLE);
    end
    @(negedge ap_clk);
    ap_rst = 1'b0;
    model_reset();
    repeat (2) step(1'b1, 1'b0, cfg_z, "reset_idle");
  endtask

  task automatic test_sequence(input cfg_t c, input string tag);
    int seq[8] = '{1, -3, 1, -7, 1, -3, 1, -7};
    do_reset();
    start_cfg(c);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (addr_incr !== 9'(seq[i])) begin
        errors++;
        $display("FAIL %s addr_incr[%0d]: got %0d, expected %0d", tag, i, $signed(addr_incr), seq[i]);
      end
      checks++;
      if (fm_last !== (i == 7)) begin
        errors++;
        $display("FAIL %s fm_last[%0d]: got %b, expected %b", tag, i, fm_last, (i == 7));
      end
      step(1'b1, 1'b0, cfg_z, tag);
    end
  endtask

  task automatic test_stall();
    do_reset();
    start_cfg(cfg_a);
    repeat (3) step(1'b1, 1'b0, cfg_z, "stall_pre");
    step(1'b1, 1'b1, cfg_b, "stall_hs");
    for (int k = 5; k <= 8; k++) begin
      checks++;
      if (cfg_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall cfg_ready before advance %0d: got %b, expected 0", k, cfg_ready);
      end
      step(1'b1, 1'b0, cfg_z, "stall_old");
    end
    checks++;
    if (cfg_ready !== 1'b1 || addr_incr !== 9'sd2) begin
      errors++;
      $display("FAIL stall swap: got ready %b addr %0d, expected ready 1 addr 2", cfg_ready, $signed(addr_incr));
    end
    repeat (12) step(1'b1, 1'b0, cfg_z, "stall_new");
  endtask

  task automatic test_latency();
    do_reset();
    repeat (9) step(1'b0, 1'b0, cfg_z, "lat_idle");
    step(1'b1, 1'b1, cfg_a, "lat_hs");
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL latency running at t+1: got %b, expected 0", running);
    end
    step(1'b1, 1'b0, cfg_z, "lat_t1");
    checks++;
    if (running !== 1'b0 || dbg_state !== LOAD) begin
      errors++;
      $display("FAIL latency at t+2 pre-edge: got running %b state %0d, expected 0 and %0d", running, dbg_state, LOAD);
    end
    step(1'b1, 1'b0, cfg_z, "lat_t2");
    checks++;
    if (running !== 1'b1 || addr_incr !== 9'sd1) begin
      errors++;
      $display("FAIL latency run start: got running %b addr %0d, expected 1 and 1", running, $signed(addr_incr));
    end
    repeat (8) step(1'b1, 1'b0, cfg_z, "lat_run");
  endtask

  task automatic test_mid_reset();
    do_reset();
    start_cfg(cfg_a);
    repeat (5) step(1'b1, 1'b0, cfg_z, "mid_pre");
    #2 ap_rst = 1'b1;
    #1;
    checks++;
    if ({running, addr_incr, tail_incr, fm_last} !== '0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid reset async: got run %b addr %h tail %h last %b ready %b, expected 0 0 0 0 1",
               running, addr_incr, tail_incr, fm_last, cfg_ready);
    end
    advance   = 1'b0;
    cfg_valid = 1'b0;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    model_reset();
    start_cfg(cfg_a);
    checks++;
    if (addr_incr !== 9'sd1 || tail_incr !== 9'd4) begin
      errors++;
      $display("FAIL mid reset restart: got addr %0d tail %0d, expected 1 and 4", $signed(addr_incr), tail_incr);
    end
    repeat (8) step(1'b1, 1'b0, cfg_z, "mid_post");
  endtask

  task automatic test_swap_at_last();
    do_reset();
    start_cfg(cfg_a);
    repeat (7) step(1'b1, 1'b0, cfg_z, "swap_first");
    step(1'b1, 1'b1, cfg_b, "swap_hs_at_last");
    checks++;
    if (addr_incr !== 9'sd1 || cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL swap 9th: got addr %0d ready %b, expected 1 and 0", $signed(addr_incr), cfg_ready);
    end
    repeat (7) step(1'b1, 1'b0, cfg_z, "swap_old_map");
    checks++;
    if (fm_last !== 1'b1 || addr_incr !== -9'sd7) begin
      errors++;
      $display("FAIL swap 16th: got last %b addr %0d, expected 1 and -7", fm_last, $signed(addr_incr));
    end
    step(1'b1, 1'b0, cfg_z, "swap_boundary");
    checks++;
    if (addr_incr !== 9'sd2 || tail_incr !== 9'd5) begin
      errors++;
      $display("FAIL swap 17th: got addr %0d tail %0d, expected 2 and 5", $signed(addr_incr), tail_incr);
    end
    repeat (12) step(1'b1, 1'b0, cfg_z, "swap_new_map");
  endtask

  initial begin
    ap_rst    = 1'b1;
    cfg_valid = 1'b0;
    advance   = 1'b0;
    cfg_data  = '0;
    model_reset();
    cfg_a  = make_cfg(2, 2, 1, 2, 1, 1, 1, 5, -3, -7, 4, 12, 20);
    cfg_a0 = cfg_a;
    cfg_a0.iter_simd = '0;
    cfg_b  = make_cfg(1, 3, 2, 1, 2, 2, 3, 6, -4, -9, 5, 11, 30);
    cfg_z  = '0;

    test_reset();
    test_sequence(cfg_a, "seq_basic");
    test_sequence(cfg_a0, "seq_simd_zero");
    test_stall();
    test_latency();
    test_mid_reset();
    test_swap_at_last();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/swg_loop_sequencer.md
SWG_LOOP_SEQUENCER -- requirements
Module: swg_loop_sequencer

Interface
REQ-001 Parameters SHALL be: INCR_BITWIDTH, 9, width of address and tail increments; CNT_BITWIDTH, 8, width of each loop-iteration field and counter.
REQ-002 ap_clk  in  1  sole clock, all state on rising edge.
REQ-003 ap_rst  in  1  reset, asynchronous, active-high.
REQ-004 cfg_valid  in  1  new loop configuration offered.
REQ-005 cfg_ready  out  1  shadow config register empty, so the offered configuration can be accepted.
REQ-006 cfg_data  in  swg_seq_pkg::cfg_t  holds the following fields:
- Loop iteration counts: iter_h, iter_w, iter_kh, iter_kw, iter_simd (unsigned, CNT_BITWIDTH).
- Head increments: head_simd, head_kw, head_kh, head_w, head_h (signed, INCR_BITWIDTH).
- Tail increments: tail_w, tail_h, tail_last (unsigned, INCR_BITWIDTH).
REQ-007 advance  in  1  the datapath consumes the current increment (one window-buffer fetch).
REQ-008 running  out  1  an active configuration is loaded, so the increments are meaningful.
REQ-009 addr_incr  out  signed INCR_BITWIDTH  read-address increment for the current fetch.
REQ-010 tail_incr  out  INCR_BITWIDTH  first-element-of-next-window increment.
REQ-011 fm_last  out  1  the current fetch is the final fetch of the feature map.

Function
REQ-012 Counters cnt_h, cnt_w, cnt_kh, cnt_kw and cnt_simd SHALL count down; each is reloaded to iter-1 (an iter field of 0 is treated as 1).
REQ-013 Level selection, outermost to innermost order H, W, KH, KW, SIMD: the selected level is the innermost level with a nonzero counter; if all counters are zero, the selected level is LAST.
REQ-014 addr_incr SHALL be the head increment of the selected level, with LAST mapping to head_h.
REQ-015 tail_incr SHALL be tail_w if cnt_w!=0, else tail_h if cnt_h!=0, else tail_last.
REQ-016 fm_last SHALL be 1 exactly when running and the selected level is LAST.
REQ-017 addr_incr, tail_incr and fm_last SHALL be decoded from registers only, with no combinational path from advance or cfg_*.
REQ-018 Advance while running SHALL decrement the selected counter and reload every counter inner to it.
REQ-019 Advance while running at LAST SHALL reload all counters, from the shadow config if one is pending (clearing the shadow), else from the active config.
REQ-020 Advance while not running SHALL be ignored, and outputs SHALL hold 0.
REQ-021 States:
- IDLE -> LOAD when the shadow is full.
- LOAD -> RUN after 1 cycle, copying shadow to active and clearing the shadow.
- RUN persists; configuration swaps happen only at a feature-map boundary, never mid-map.
REQ-022 The cfg handshake SHALL complete on a cycle with cfg_valid && cfg_ready; cfg_ready = !shadow_full, so a second configuration stalls until the shadow drains.
REQ-023 Latency from IDLE: handshake at edge t, running=1 after edge t+2.
REQ-024 A handshake in the same cycle as a LAST advance with an empty shadow SHALL fill the shadow only; the next feature map uses the old configuration.
REQ-025 Counter arithmetic SHALL be unsigned, with no wrap below 0, and increments SHALL pass through unmodified (no saturation).

Reset
REQ-026 Asserting ap_rst SHALL force, immediately and regardless of the clock: IDLE, shadow empty, active config and counters 0, cfg_ready=1, running=0, addr_incr=0, tail_incr=0, fm_last=0.
REQ-027 Reset mid-feature-map SHALL discard all progress, and the first post-reset handshake SHALL start a fresh map.

Structure
REQ-028 Package swg_seq_pkg SHALL hold cfg_t, the state enum (IDLE/LOAD/RUN), the level enum (SIMD/KW/KH/W/H/LAST) and the default width constants.
REQ-029 One sub-module, swg_seq_loop_counter (a down-counter with reload and is_zero), SHALL be instantiated five times.

Verification
REQ-030 Config iter H=2, W=2, KH=1, KW=2, SIMD=1; heads simd 1, kw 1, kh 5, w -3, h -7; tails w 4, h 12, last 20.
- Stimulus: 8 consecutive advances.
- Required addr_incr sequence: 1,-3,1,-7,1,-3,1,-7.
- Required fm_last: only on the 8th advance.
REQ-031 Same config:
- Stimulus: a second config handshaked after the 3rd advance.
- Required: cfg_ready=0 until the 8th advance, and the 9th advance uses the new config.
REQ-032 Stimulus: handshake in IDLE at cycle 10.
- Required: running=0 at cycle 11, running=1 at cycle 12.
- Required: advance before cycle 12 leaves the counters unchanged.
REQ-033 Stimulus: assert ap_rst between clock edges after the 5th advance.
- Required: outputs 0 and cfg_ready=1 immediately.
- Required: a re-handshake restarts the sequence at 1.
REQ-034 Stimulus: iter_simd=0 with other fields as REQ-030.
- Required: a sequence identical to REQ-030.
REQ-035 Stimulus: a handshake coinciding with the 8th advance.
- Required: the 9th-16th advances repeat the old sequence, and the 17th advance uses the new config.
